// File: rtl/usb_tx_scheduler.sv
// Transmit packet scheduler: arbitrates RX IQ half-buffer packets against
// bandscope frame packets and paces bandscope captures in milliseconds.
module usb_tx_scheduler #(
  parameter int unsigned TICK_DIV   = 60000,
  parameter int unsigned BS_PACKETS = 67
) (
  input  logic       usb_clock,
  input  logic       reset,
  input  logic       rx_on,
  input  logic       bs_on,
  input  logic [7:0] bs_period,
  input  logic       rx_block,
  input  logic       bs_ready,
  input  logic       pkt_done,
  output logic       pkt_req,
  output logic       pkt_type,
  output logic       pkt_block,
  output logic [7:0] pkt_pn,
  output logic       bs_arm,
  output logic       rx_overrun
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    PN_LAST    = 8'(BS_PACKETS - 1);

  typedef enum logic [1:0] {
    M_IDLE,
    M_RX_BUSY,
    M_BS_BUSY
  } main_state_t;

  typedef enum logic [2:0] {
    BS_OFF,
    BS_ARM,
    BS_WAIT_CAP,
    BS_SEND,
    BS_GAP
  } bs_state_t;

  main_state_t   main_state;
  bs_state_t     bs_state;

  logic          primed;
  logic          rx_seen;
  logic          bs_seen;
  logic          rx_pend;
  logic          rx_half;
  logic          bs_pend;
  logic [7:0]    pn;
  logic [PW-1:0] presc;
  logic [7:0]    gap_cnt;

  logic          rx_toggle;
  logic          bs_toggle;
  logic          ms_tick;
  logic          grant_rx;
  logic          bs_done_evt;
  logic [7:0]    period_target;

  always_comb begin
    rx_toggle     = primed && (rx_block != rx_seen);
    bs_toggle     = primed && (bs_ready != bs_seen);
    ms_tick       = (presc == PRESC_LAST);
    grant_rx      = (main_state == M_IDLE) && rx_pend;
    bs_done_evt   = (main_state == M_BS_BUSY) && pkt_done;
    period_target = (bs_period == 8'd0) ? 8'd1 : bs_period;
  end

  // Edge detectors are primed from the live levels on the first cycle out of
  // reset so a non-zero level at release is not mistaken for a toggle.
  always_ff @(posedge usb_clock or negedge reset) begin
    if (!reset) begin
      primed     <= 1'b0;
      rx_seen    <= 1'b0;
      bs_seen    <= 1'b0;
      rx_pend    <= 1'b0;
      rx_half    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (!primed || rx_toggle)
        rx_seen <= rx_block;
      if (!primed || bs_toggle)
        bs_seen <= bs_ready;

      if (!rx_on) begin
        rx_pend    <= 1'b0;
        rx_overrun <= 1'b0;
      end else if (rx_toggle) begin
        rx_pend <= 1'b1;
        rx_half <= rx_block;
        if (rx_pend)
          rx_overrun <= 1'b1;
      end else if (grant_rx) begin
        rx_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge usb_clock or negedge reset) begin
    if (!reset) begin
      main_state <= M_IDLE;
      pkt_req    <= 1'b0;
      pkt_type   <= 1'b0;
      pkt_block  <= 1'b0;
      pkt_pn     <= '0;
    end else begin
      case (main_state)
        M_IDLE: begin
          if (rx_pend) begin
            main_state <= M_RX_BUSY;
            pkt_req    <= 1'b1;
            pkt_type   <= 1'b0;
            pkt_block  <= rx_half;
            pkt_pn     <= pn;
          end else if (bs_pend) begin
            main_state <= M_BS_BUSY;
            pkt_req    <= 1'b1;
            pkt_type   <= 1'b1;
            pkt_block  <= rx_half;
            pkt_pn     <= pn;
          end
        end
        default: begin
          if (pkt_done) begin
            main_state <= M_IDLE;
            pkt_req    <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge usb_clock or negedge reset) begin
    if (!reset) begin
      bs_state <= BS_OFF;
      bs_arm   <= 1'b0;
      bs_pend  <= 1'b0;
      pn       <= '0;
      presc    <= '0;
      gap_cnt  <= '0;
    end else if (!bs_on) begin
      bs_state <= BS_OFF;
      bs_arm   <= 1'b0;
      bs_pend  <= 1'b0;
      pn       <= '0;
      presc    <= '0;
      gap_cnt  <= '0;
    end else begin
      bs_arm <= 1'b0;
      case (bs_state)
        BS_OFF:  bs_state <= BS_ARM;
        BS_ARM: begin
          bs_arm   <= 1'b1;
          bs_state <= BS_WAIT_CAP;
        end
        BS_WAIT_CAP: begin
          if (bs_toggle) begin
            bs_state <= BS_SEND;
            bs_pend  <= 1'b1;
          end
        end
        BS_SEND: begin
          if (bs_done_evt) begin
            if (pn < PN_LAST) begin
              pn <= pn + 8'd1;
            end else begin
              pn       <= '0;
              bs_pend  <= 1'b0;
              presc    <= '0;
              gap_cnt  <= '0;
              bs_state <= BS_GAP;
            end
          end
        end
        BS_GAP: begin
          // Compare the registered count so ARM is entered one cycle after
          // the final tick; bs_arm then follows on the next edge.
          if (gap_cnt == period_target) begin
            presc    <= '0;
            gap_cnt  <= '0;
            bs_state <= BS_ARM;
          end else if (ms_tick) begin
            presc   <= '0;
            gap_cnt <= gap_cnt + 8'd1;
          end else begin
            presc <= presc + PW'(1);
          end
        end
        default: bs_state <= BS_OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler: priming, RX grant/overrun, bandscope
// frames with interleaved RX, bs_on drop mid-frame and async reset.
module tb_usb_tx_scheduler;

  logic       usb_clock;
  logic       reset;
  logic       rx_on;
  logic       bs_on;
  logic [7:0] bs_period;
  logic       rx_block;
  logic       bs_ready;
  logic       pkt_done;
  logic       pkt_req;
  logic       pkt_type;
  logic       pkt_block;
  logic [7:0] pkt_pn;
  logic       bs_arm;
  logic       rx_overrun;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  usb_tx_scheduler #(
    .TICK_DIV   (10),
    .BS_PACKETS (67)
  ) dut (
    .usb_clock  (usb_clock),
    .reset      (reset),
    .rx_on      (rx_on),
    .bs_on      (bs_on),
    .bs_period  (bs_period),
    .rx_block   (rx_block),
    .bs_ready   (bs_ready),
    .pkt_done   (pkt_done),
    .pkt_req    (pkt_req),
    .pkt_type   (pkt_type),
    .pkt_block  (pkt_block),
    .pkt_pn     (pkt_pn),
    .bs_arm     (bs_arm),
    .rx_overrun (rx_overrun)
  );

  initial usb_clock = 1'b0;
  always #5 usb_clock = ~usb_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge usb_clock);
    #1;
  endtask

  task automatic done_pulse();
    pkt_done = 1'b1;
    step();
    pkt_done = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int unsigned n = 0;
    while (!pkt_req && n < 16) begin
      step();
      n++;
    end
    chk(tag, 32'(pkt_req), 32'd1);
  endtask

  task automatic wait_arm(input string tag, input int unsigned exp_cycles);
    int unsigned n = 0;
    bit saw_req = 1'b0;
    do begin
      step();
      n++;
      if (pkt_req) saw_req = 1'b1;
    end while (!bs_arm && n < exp_cycles + 8);
    chk(tag, n, exp_cycles);
    chk({tag, "_noreq"}, 32'(saw_req), 32'd0);
  endtask

  // Runs BS packets 0..npk-1; with mix set, an RX toggle is injected every
  // third packet, alternately before and together with pkt_done.
  task automatic bs_frame(input int unsigned npk, input bit mix);
    bit mid;
    for (int p = 0; p < int'(npk); p++) begin
      wait_req("bs_req_timeout");
      chk("bs_pkt", 32'({pkt_type, pkt_pn}), 32'({1'b1, 8'(p)}));
      mid = mix && (p % 3 == 2) && (p < 66);
      if (mid && (p % 6 == 2)) begin
        rx_block = ~rx_block;
        step();
      end
      if (mid && (p % 6 == 5))
        rx_block = ~rx_block;
      done_pulse();
      if (mid) begin
        wait_req("rx_req_timeout");
        chk("rx_between", 32'({pkt_type, pkt_block}), 32'({1'b0, rx_block}));
        done_pulse();
      end
    end
  endtask

  initial begin
    bit saw;
    reset     = 1'b0;
    rx_on     = 1'b1;
    bs_on     = 1'b0;
    bs_period = 8'd3;
    rx_block  = 1'b1;
    bs_ready  = 1'b1;
    pkt_done  = 1'b0;

    step();
    step();
    chk("rst_outputs", 32'({pkt_req, pkt_type, pkt_block, bs_arm, rx_overrun, pkt_pn}), 32'd0);

    // Priming: high levels at release must not raise a request
    reset = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pkt_req) saw = 1'b1;
    end
    chk("prime_noreq", 32'(saw), 32'd0);

    // RX grant latency: toggle sampled at N, pkt_req after N+1
    rx_block = 1'b0;
    step();
    chk("rx_lat_n", 32'(pkt_req), 32'd0);
    step();
    chk("rx_grant0", 32'({pkt_req, pkt_type, pkt_block}), 32'b100);
    saw = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (!pkt_req) saw = 1'b1;
    end
    chk("rx_hold", 32'(saw), 32'd0);
    done_pulse();
    chk("rx_drop", 32'(pkt_req), 32'd0);

    rx_block = 1'b1;
    step();
    step();
    chk("rx_grant1", 32'({pkt_req, pkt_type, pkt_block}), 32'b101);

    // Overrun: two toggles while the packet is held
    rx_block = 1'b0;
    step();
    chk("ovr_first", 32'(rx_overrun), 32'd0);
    rx_block = 1'b1;
    step();
    rx_block = 1'b0;
    step();
    chk("ovr_set", 32'(rx_overrun), 32'd1);
    done_pulse();
    chk("ovr_idle", 32'(pkt_req), 32'd0);
    step();
    chk("ovr_regrant", 32'({pkt_req, pkt_type, pkt_block}), 32'b100);
    done_pulse();
    chk("ovr_sticky", 32'(rx_overrun), 32'd1);
    rx_on = 1'b0;
    step();
    chk("ovr_clear", 32'(rx_overrun), 32'd0);
    rx_on = 1'b1;
    step();

    // Bandscope frame 1: arm 2 cycles after enable, 67 packets, 3 ms gap
    bs_on = 1'b1;
    wait_arm("arm_enable", 2);
    step();
    chk("arm_one_cycle", 32'(bs_arm), 32'd0);
    bs_ready = ~bs_ready;
    bs_frame(67, 1'b0);
    wait_arm("arm_gap3", 32);

    // Frame 2 with interleaved RX
    bs_ready = ~bs_ready;
    bs_frame(67, 1'b1);
    chk("mix_no_overrun", 32'(rx_overrun), 32'd0);
    wait_arm("arm_gap3b", 32);

    // Frame 3: drop bs_on while PN 20 is granted
    bs_period = 8'd0;
    bs_ready = ~bs_ready;
    bs_frame(20, 1'b0);
    wait_req("bs20_timeout");
    bs_on = 1'b0;
    step();
    step();
    chk("bs20_hold", 32'({pkt_req, pkt_type, pkt_pn}), 32'({1'b1, 1'b1, 8'd20}));
    done_pulse();
    chk("bs20_drop", 32'(pkt_req), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pkt_req || bs_arm) saw = 1'b1;
    end
    chk("bs_off_quiet", 32'(saw), 32'd0);

    // Re-enable: PN restarts at 0; period 0 behaves as 1 ms
    bs_on = 1'b1;
    wait_arm("arm_reenable", 2);
    bs_ready = ~bs_ready;
    bs_frame(67, 1'b0);
    wait_arm("arm_gap0", 12);

    // Asynchronous reset mid-packet
    rx_block = ~rx_block;
    step();
    step();
    chk("pre_async", 32'(pkt_req), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst", 32'({pkt_req, pkt_type, pkt_block, bs_arm, rx_overrun, pkt_pn}), 32'd0);
    #3;
    reset = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pkt_req) saw = 1'b1;
    end
    chk("post_async_noreq", 32'(saw), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
